// File: rtl/cpu_types_pkg.sv
// Shared types and default constants for the pipeline controller.
//   pipe_state_e : controller FSM states
//   *_DEF        : default values for the pipeline_ctrl parameters
package cpu_types_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } pipe_state_e;

    localparam int unsigned NREGS_DEF     = 4;
    localparam int unsigned LU_IDX_DEF    = 1;
    localparam int unsigned REDIR_IDX_DEF = 1;
    localparam int unsigned HALT_IDX_DEF  = 3;
    localparam int unsigned DRAIN_CYC_DEF = 1;
    localparam int unsigned TIMEOUT_DEF   = 255;
    localparam int unsigned CNT_W_DEF     = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : zero the count (wins over inc)
//   inc       : add one, holding at all-ones
//   value     : current count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            value_q <= '0;
        end else if (clear) begin
            value_q <= '0;
        end else if (inc && (value_q != '1)) begin
            value_q <= value_q + CNT_W'(1);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/flush controller for an in-order core.
//   CLK, nRST          : clock, asynchronous active-low reset
//   ihit, dhit         : fetch / data access complete this cycle
//   mem_req            : MEM-stage register holds a memory op
//   load_use           : ID instruction needs the EX-stage load result
//   redirect           : taken branch/jump resolved in EX
//   halt_req           : halt instruction in the MEM-stage register
//   pc_en              : PC update enable (combinational)
//   reg_en, reg_flush  : per pipeline register enable / clear (combinational)
//   halt, mem_timeout  : sticky status flags (registered)
//   stall_cnt          : stalled or bubbled cycles, saturating
//   flush_cnt          : redirects taken, saturating
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS     = NREGS_DEF,
    parameter int unsigned LU_IDX    = LU_IDX_DEF,
    parameter int unsigned REDIR_IDX = REDIR_IDX_DEF,
    parameter int unsigned HALT_IDX  = HALT_IDX_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             halt_req,
    output logic             pc_en,
    output logic [NREGS-1:0] reg_en,
    output logic [NREGS-1:0] reg_flush,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    pipe_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               halt_q;
    logic               mem_timeout_q;

    logic               active;
    logic               mstall;
    logic               adv;
    logic               pc_en_c;
    logic [NREGS-1:0]   reg_en_c;
    logic [NREGS-1:0]   reg_flush_c;

    logic               stall_inc;
    logic               flush_inc;
    logic               wait_inc;
    logic [CNT_W-1:0]   wait_cnt;

    // Hazard qualifiers shared by RUN and MEM_WAIT
    assign active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign mstall = mem_req && !dhit;
    assign adv    = active && ihit && !mstall;

    // Next state and zero-latency pipeline control
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en_c     = 1'b0;
        reg_en_c    = '0;
        reg_flush_c = '0;

        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (adv) begin
                    if (redirect) begin
                        pc_en_c  = 1'b1;
                        reg_en_c = '1;
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            reg_flush_c[i] = (i <= REDIR_IDX);
                        end
                    end else if (load_use) begin
                        // Hold the front of the pipe, insert a bubble at LU_IDX
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            reg_en_c[i] = (i >= LU_IDX);
                        end
                        reg_flush_c[LU_IDX] = 1'b1;
                    end else begin
                        pc_en_c  = 1'b1;
                        reg_en_c = '1;
                    end
                end

                if (adv && halt_req) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYC);
                    end
                end else if ((state_q == ST_RUN) && mstall) begin
                    state_d = ST_MEM_WAIT;
                end else if ((state_q == ST_MEM_WAIT) && dhit) begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                // Only the back end keeps moving; HALT_IDX gets one bubble on entry
                for (int unsigned i = 0; i < NREGS; i++) begin
                    reg_en_c[i] = (i >= HALT_IDX);
                end
                reg_flush_c[HALT_IDX] = (drain_q == DRAIN_W'(DRAIN_CYC));
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = ST_HALTED;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    // State and sticky flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_RUN;
            drain_q       <= '0;
            halt_q        <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (state_d == ST_HALTED) begin
                halt_q <= 1'b1;
            end
            // Flag rises on the edge that brings the wait count to TIMEOUT
            if (wait_inc && (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    // Every memory-stalled cycle counts as a wait cycle, including the RUN cycle
    // that enters MEM_WAIT; any non-stalled cycle breaks the run.
    assign wait_inc  = active && mstall;
    assign stall_inc = active && (!adv || (load_use && !redirect));
    assign flush_inc = adv && redirect;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (flush_inc),
        .value (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (!wait_inc),
        .inc   (wait_inc),
        .value (wait_cnt)
    );

    // Control outputs are forced idle while reset is held
    assign pc_en       = nRST && pc_en_c;
    assign reg_en      = nRST ? reg_en_c : '0;
    assign reg_flush   = nRST ? reg_flush_c : '0;
    assign halt        = halt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int unsigned NR   = 4;
    localparam int unsigned LU   = 1;
    localparam int unsigned RDX  = 1;
    localparam int unsigned HIX  = 3;
    localparam int unsigned DCYC = 1;
    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 6;
    localparam int          CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit = 1'b0, dhit = 1'b0, mem_req = 1'b0;
    logic          load_use = 1'b0, redirect = 1'b0, halt_req = 1'b0;
    logic          pc_en;
    logic [NR-1:0] reg_en, reg_flush;
    logic          halt, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(
        .NREGS(NR), .LU_IDX(LU), .REDIR_IDX(RDX), .HALT_IDX(HIX),
        .DRAIN_CYC(DCYC), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .load_use(load_use), .redirect(redirect), .halt_req(halt_req),
        .pc_en(pc_en), .reg_en(reg_en), .reg_flush(reg_flush),
        .halt(halt), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: halted flag, cycles left in drain, run of memory waits
    bit m_halted, m_draining, m_first, m_tout;
    int m_left, m_waitrun, m_stall, m_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_draining = 0; m_first = 0; m_tout = 0;
        m_left = 0; m_waitrun = 0; m_stall = 0; m_flush = 0;
    endtask

    // Called one time unit after a rising edge; holds nRST low for one cycle
    task automatic reset_dut(input string tag);
        nRST = 1'b0;
        ihit = 1'b1; redirect = 1'b1; mem_req = 1'b0; dhit = 1'b0;
        load_use = 1'b0; halt_req = 1'b0;
        #4;
        chk({tag, "_rst_pc_en"}, 64'(pc_en), 64'(0));
        chk({tag, "_rst_reg_en"}, 64'(reg_en), 64'(0));
        chk({tag, "_rst_flush"}, 64'(reg_flush), 64'(0));
        chk({tag, "_rst_halt"}, 64'(halt), 64'(0));
        chk({tag, "_rst_tout"}, 64'(mem_timeout), 64'(0));
        chk({tag, "_rst_stall"}, 64'(stall_cnt), 64'(0));
        chk({tag, "_rst_flushcnt"}, 64'(flush_cnt), 64'(0));
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        ihit = 1'b0; redirect = 1'b0;
        model_reset();
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic step(input bit ih, input bit dh, input bit mr, input bit lu,
                        input bit rd, input bit hr, input string tag);
        bit run, mst, adv;
        logic [NR-1:0] e_en, e_fl;
        bit e_pc;
        ihit = ih; dhit = dh; mem_req = mr; load_use = lu; redirect = rd; halt_req = hr;
        #4;
        run  = !m_halted && !m_draining;
        mst  = mr && !dh;
        adv  = run && ih && !mst;
        e_pc = 1'b0; e_en = '0; e_fl = '0;
        if (adv && rd) begin
            e_pc = 1'b1; e_en = '1;
            for (int i = 0; i <= int'(RDX); i++) e_fl[i] = 1'b1;
        end else if (adv && lu) begin
            for (int i = int'(LU); i < int'(NR); i++) e_en[i] = 1'b1;
            e_fl[LU] = 1'b1;
        end else if (adv) begin
            e_pc = 1'b1; e_en = '1;
        end else if (m_draining) begin
            for (int i = int'(HIX); i < int'(NR); i++) e_en[i] = 1'b1;
            e_fl[HIX] = m_first;
        end
        chk({tag, "_pc_en"}, 64'(pc_en), 64'(e_pc));
        chk({tag, "_reg_en"}, 64'(reg_en), 64'(e_en));
        chk({tag, "_reg_flush"}, 64'(reg_flush), 64'(e_fl));
        chk({tag, "_halt"}, 64'(halt), 64'(m_halted));
        chk({tag, "_mem_timeout"}, 64'(mem_timeout), 64'(m_tout));
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
        @(posedge CLK);
        #1;
        if (run) begin
            if ((!adv || (lu && !rd)) && m_stall < CMAX) m_stall++;
            if (adv && rd && m_flush < CMAX) m_flush++;
            if (mst) begin
                m_waitrun++;
                if (m_waitrun == int'(TO)) m_tout = 1;
            end else begin
                m_waitrun = 0;
            end
            if (adv && hr) begin
                if (DCYC == 0) m_halted = 1;
                else begin m_draining = 1; m_left = int'(DCYC); m_first = 1; end
            end
        end else begin
            m_waitrun = 0;
            if (m_draining) begin
                m_first = 0;
                m_left--;
                if (m_left == 0) begin m_draining = 0; m_halted = 1; end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        reset_dut("por");

        // Free-running pipeline
        repeat (10) step(1, 0, 0, 0, 0, 0, "run");
        chk("run_stall_zero", 64'(stall_cnt), 64'(0));
        chk("run_reg_en_all", 64'(reg_en), 64'(4'b1111));

        // Memory stall for three cycles then data returns
        repeat (3) step(1, 0, 1, 0, 0, 0, "memwait");
        step(1, 1, 1, 0, 0, 0, "memdone");
        chk("memwait_stall3", 64'(stall_cnt), 64'(3));
        chk("memwait_state_run", 64'(dut.state_q), 64'(ST_RUN));

        // Redirect beats load-use; then load-use alone
        step(1, 0, 0, 1, 1, 0, "redir_lu");
        chk("redir_flush_cnt", 64'(flush_cnt), 64'(1));
        step(1, 0, 0, 1, 0, 0, "lu_only");
        step(0, 0, 0, 1, 1, 0, "no_ihit");

        // Long memory wait trips the timeout, which stays set afterwards
        repeat (6) step(1, 0, 1, 0, 0, 0, "tout_wait");
        step(1, 1, 1, 0, 0, 0, "tout_done");
        repeat (3) step(1, 0, 0, 0, 0, 0, "tout_after");
        chk("tout_sticky", 64'(mem_timeout), 64'(1));

        // Stall counter saturation
        repeat (70) step(0, 0, 0, 0, 0, 0, "sat");
        chk("stall_saturated", 64'(stall_cnt), 64'(CMAX));

        // Halt with a stalled halt_req first (must not start draining)
        step(1, 0, 1, 0, 0, 1, "halt_stalled");
        step(1, 1, 1, 0, 0, 1, "halt_req");
        step(1, 0, 0, 0, 1, 0, "drain");
        repeat (3) step(1, 0, 0, 1, 1, 0, "halted");
        chk("halted_flag", 64'(halt), 64'(1));

        // Reset mid-drain discards progress
        reset_dut("post_halt");
        step(1, 0, 0, 0, 0, 0, "pre_drain");
        step(1, 0, 0, 0, 0, 1, "halt_req2");
        reset_dut("mid_drain");
        chk("mid_drain_state", 64'(dut.state_q), 64'(ST_RUN));
        step(1, 0, 0, 0, 0, 0, "after_drain_rst");

        // Reset mid memory wait
        repeat (2) step(1, 0, 1, 0, 0, 0, "mw_pre");
        reset_dut("mid_memwait");
        chk("mid_memwait_state", 64'(dut.state_q), 64'(ST_RUN));

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                reset_dut("rnd_rst");
            end else begin
                step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                     $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
